// File: rtl/pipe_buf.sv
// pipe_buf: small circular FIFO between fetch and decode. It holds {ins, pc, nop}
// entries and drives the head from storage, so the output is always registered.
// It accepts a push on the same cycle as a pop when full, which keeps one entry
// per cycle of throughput even when DEPTH is 1.
module pipe_buf #(
    parameter int                INS_W   = 32,
    parameter int                PC_W    = 64,
    parameter int                DEPTH   = 2,
    parameter logic [INS_W-1:0]  NOP_INS = INS_W'(32'h13)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,
    input  logic                         i_pre_nop,
    input  logic                         i_pre_stall,
    input  logic                         i_pre_valid,
    output logic                         o_pre_ready,
    input  logic [INS_W-1:0]             i_ifu_ins,
    input  logic [PC_W-1:0]              i_ifu_pc,
    output logic                         o_post_valid,
    input  logic                         i_post_ready,
    output logic [INS_W-1:0]             o_ins,
    output logic [PC_W-1:0]              o_pc,
    output logic                         o_nop,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [INS_W-1:0] ins_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic             nop_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic full;
    logic push;
    logic pop;

    // Pointer advance with explicit wrap so non-power-of-two widths stay correct.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full = (count == CNT_W'(DEPTH));
    assign pop  = (count != '0) & i_post_ready;
    // Reset makes the buffer look empty to the producer; flush does not gate ready.
    assign o_pre_ready = !i_pre_stall & (i_rst | !full | pop);
    assign push = i_pre_valid & o_pre_ready;

    // Storage, pointers and occupancy; reset beats flush, flush beats handshakes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ins_mem[i] <= '0;
                pc_mem[i]  <= '0;
                nop_mem[i] <= 1'b0;
            end
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                ins_mem[wr_ptr] <= i_pre_nop ? NOP_INS : i_ifu_ins;
                pc_mem[wr_ptr]  <= i_ifu_pc;
                nop_mem[wr_ptr] <= i_pre_nop;
                wr_ptr          <= next_ptr(wr_ptr);
            end
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    assign o_post_valid = (count != '0);
    assign o_ins        = ins_mem[rd_ptr];
    assign o_pc         = pc_mem[rd_ptr];
    assign o_nop        = nop_mem[rd_ptr];
    assign o_count      = count;
    assign o_full       = full;

endmodule

// File: tb/tb_pipe_buf.sv
// tb_pipe_buf: drives three pipe_buf instances (DEPTH 1, 2, 4) from shared inputs
// and compares each against its own queue-based reference model.
module tb_pipe_buf;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
        logic        nop;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, pre_nop, pre_stall, pre_valid, post_ready;
    logic [31:0] ifu_ins;
    logic [63:0] ifu_pc;

    logic        rdy   [3];
    logic        pv    [3];
    logic [31:0] ins_o [3];
    logic [63:0] pc_o  [3];
    logic        nop_o [3];
    logic        full_o[3];
    logic [0:0]  c1;
    logic [1:0]  c2;
    logic [2:0]  c4;

    int   dep [3] = '{1, 2, 4};
    ent_t q [3][$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_buf #(.DEPTH(1)) u_d1 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_pre_nop(pre_nop),
        .i_pre_stall(pre_stall), .i_pre_valid(pre_valid), .o_pre_ready(rdy[0]),
        .i_ifu_ins(ifu_ins), .i_ifu_pc(ifu_pc), .o_post_valid(pv[0]),
        .i_post_ready(post_ready), .o_ins(ins_o[0]), .o_pc(pc_o[0]),
        .o_nop(nop_o[0]), .o_count(c1), .o_full(full_o[0]));

    pipe_buf #(.DEPTH(2)) u_d2 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_pre_nop(pre_nop),
        .i_pre_stall(pre_stall), .i_pre_valid(pre_valid), .o_pre_ready(rdy[1]),
        .i_ifu_ins(ifu_ins), .i_ifu_pc(ifu_pc), .o_post_valid(pv[1]),
        .i_post_ready(post_ready), .o_ins(ins_o[1]), .o_pc(pc_o[1]),
        .o_nop(nop_o[1]), .o_count(c2), .o_full(full_o[1]));

    pipe_buf #(.DEPTH(4)) u_d4 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_pre_nop(pre_nop),
        .i_pre_stall(pre_stall), .i_pre_valid(pre_valid), .o_pre_ready(rdy[2]),
        .i_ifu_ins(ifu_ins), .i_ifu_pc(ifu_pc), .o_post_valid(pv[2]),
        .i_post_ready(post_ready), .o_ins(ins_o[2]), .o_pc(pc_o[2]),
        .o_nop(nop_o[2]), .o_count(c4), .o_full(full_o[2]));

    function automatic int get_cnt(input int i);
        if (i == 0) return int'(c1);
        if (i == 1) return int'(c2);
        return int'(c4);
    endfunction

    // Producer may hand over an entry if not stalled and there is (or will be) room.
    function automatic bit mready(input int i);
        return !pre_stall && (rst || q[i].size() < dep[i] ||
                              (q[i].size() > 0 && post_ready));
    endfunction

    // Advance one clock and apply the same transfer to each reference queue.
    task automatic tick();
        bit   mpu [3];
        bit   mpo [3];
        ent_t e;
        @(negedge clk);
        e.ins = pre_nop ? 32'h13 : ifu_ins;
        e.pc  = ifu_pc;
        e.nop = pre_nop;
        for (int i = 0; i < 3; i++) begin
            mpu[i] = pre_valid && mready(i);
            mpo[i] = q[i].size() > 0 && post_ready;
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst || flush) q[i].delete();
            else begin
                if (mpo[i]) void'(q[i].pop_front());
                if (mpu[i]) q[i].push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; flush = 0; pre_nop = 0; pre_stall = 0; pre_valid = 0;
        post_ready = 0; ifu_ins = '0; ifu_pc = '0;
    endtask

    task automatic clear();
        idle_inputs();
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; pre_valid = 1; ifu_pc = 64'h55;
        tick();
        #1;
        checks++;
        if (rdy[2] !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b exp 1", rdy[2]);
        end
        tick();
        idle_inputs();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pv[i] !== 1'b0 || ins_o[i] !== 32'h0 || pc_o[i] !== 64'h0 ||
                nop_o[i] !== 1'b0 || get_cnt(i) != 0 || full_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outs[%0d] got v=%b ins=%h pc=%h nop=%b cnt=%0d full=%b exp all zero",
                         i, pv[i], ins_o[i], pc_o[i], nop_o[i], get_cnt(i), full_o[i]);
            end
        end
    endtask

    task automatic test_fill();
        clear();
        pre_valid = 1; ifu_ins = 32'h1111; ifu_pc = 64'h8000_0000;
        tick();
        ifu_ins = 32'h2222; ifu_pc = 64'h8000_0004;
        tick();
        ifu_pc = 64'h8000_0008;
        #1;
        checks++;
        if (c2 !== 2'd2 || full_o[1] !== 1'b1 || rdy[1] !== 1'b0 || pc_o[1] !== 64'h8000_0000) begin
            errors++;
            $display("FAIL fill_d2 got cnt=%0d full=%b rdy=%b pc=%h exp 2 1 0 80000000",
                     c2, full_o[1], rdy[1], pc_o[1]);
        end
        tick();
        checks++;
        if (c2 !== 2'd2 || pc_o[1] !== 64'h8000_0000 || ins_o[1] !== 32'h1111) begin
            errors++;
            $display("FAIL fill_hold got cnt=%0d pc=%h ins=%h exp 2 80000000 1111", c2, pc_o[1], ins_o[1]);
        end
        pre_valid = 0;
    endtask

    task automatic test_nop();
        clear();
        pre_valid = 1; pre_nop = 1; ifu_ins = 32'h00A0_0093; ifu_pc = 64'h1000;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pv[i] !== 1'b1 || ins_o[i] !== 32'h13 || nop_o[i] !== 1'b1 || pc_o[i] !== 64'h1000) begin
                errors++;
                $display("FAIL nop[%0d] got v=%b ins=%h nop=%b pc=%h exp 1 00000013 1 1000",
                         i, pv[i], ins_o[i], nop_o[i], pc_o[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] base = 64'h8000_0100;
        clear();
        pre_valid = 1; post_ready = 1;
        for (int k = 0; k < 8; k++) begin
            ifu_pc = base + 64'(4 * k);
            ifu_ins = 32'(k);
            #1;
            checks++;
            if (rdy[0] !== 1'b1) begin
                errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", k, rdy[0]);
            end
            tick();
            checks++;
            if (pv[0] !== 1'b1 || pc_o[0] !== base + 64'(4 * k) || ins_o[0] !== 32'(k)) begin
                errors++;
                $display("FAIL b2b_head[%0d] got v=%b pc=%h ins=%h exp 1 %h %h",
                         k, pv[0], pc_o[0], ins_o[0], base + 64'(4 * k), k);
            end
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        clear();
        pre_valid = 1;
        for (int k = 0; k < 4; k++) begin
            ifu_pc = 64'h2000 + 64'(4 * k);
            tick();
        end
        checks++;
        if (c4 !== 3'd4 || full_o[2] !== 1'b1) begin
            errors++; $display("FAIL flush_prefill got cnt=%0d full=%b exp 4 1", c4, full_o[2]);
        end
        post_ready = 1; flush = 1; ifu_pc = 64'hDEAD0;
        #1;
        checks++;
        if (rdy[2] !== 1'b1) begin
            errors++; $display("FAIL flush_ready got %b exp 1", rdy[2]);
        end
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (get_cnt(i) != 0 || pv[i] !== 1'b0) begin
                errors++; $display("FAIL flush_empty[%0d] got cnt=%0d v=%b exp 0 0", i, get_cnt(i), pv[i]);
            end
        end
        pre_valid = 1; ifu_pc = 64'h3000;
        tick();
        idle_inputs();
        checks++;
        if (c4 !== 3'd1 || pc_o[2] !== 64'h3000) begin
            errors++; $display("FAIL flush_after got cnt=%0d pc=%h exp 1 3000", c4, pc_o[2]);
        end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int n = 0; n < 300; n++) begin
            pre_valid  = ($urandom % 4) != 0;
            post_ready = ($urandom % 3) != 0;
            pre_stall  = ($urandom % 5) == 0;
            pre_nop    = ($urandom % 6) == 0;
            flush      = ($urandom % 40) == 0;
            ifu_ins    = $urandom;
            ifu_pc     = {$urandom, $urandom};
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rdy[i] !== mready(i)) begin
                    errors++; $display("FAIL rand_ready[%0d] cyc %0d got %b exp %b", i, n, rdy[i], mready(i));
                end
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (pv[i] !== (q[i].size() > 0) || get_cnt(i) != q[i].size() ||
                    full_o[i] !== (q[i].size() == dep[i])) begin
                    errors++;
                    $display("FAIL rand_state[%0d] cyc %0d got v=%b cnt=%0d full=%b exp cnt=%0d",
                             i, n, pv[i], get_cnt(i), full_o[i], q[i].size());
                end else if (q[i].size() > 0) begin
                    checks++;
                    if (ins_o[i] !== q[i][0].ins || pc_o[i] !== q[i][0].pc || nop_o[i] !== q[i][0].nop) begin
                        errors++;
                        $display("FAIL rand_head[%0d] cyc %0d got ins=%h pc=%h nop=%b exp %h %h %b",
                                 i, n, ins_o[i], pc_o[i], nop_o[i], q[i][0].ins, q[i][0].pc, q[i][0].nop);
                    end
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        clear();
        pre_valid = 1;
        for (int k = 0; k < 3; k++) begin
            ifu_pc = 64'h4000 + 64'(4 * k);
            tick();
        end
        checks++;
        if (c4 !== 3'd3) begin
            errors++; $display("FAIL rmid_fill got cnt=%0d exp 3", c4);
        end
        rst = 1; post_ready = 1; ifu_pc = 64'h4444;
        #1;
        checks++;
        if (rdy[0] !== 1'b1) begin
            errors++; $display("FAIL rmid_ready got %b exp 1", rdy[0]);
        end
        tick();
        rst = 0; post_ready = 0; ifu_ins = 32'h77; ifu_pc = 64'h5000;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pv[i] !== 1'b0 || ins_o[i] !== 32'h0 || pc_o[i] !== 64'h0 ||
                nop_o[i] !== 1'b0 || get_cnt(i) != 0 || full_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL rmid_zero[%0d] got v=%b ins=%h pc=%h nop=%b cnt=%0d full=%b exp all zero",
                         i, pv[i], ins_o[i], pc_o[i], nop_o[i], get_cnt(i), full_o[i]);
            end
        end
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pv[i] !== 1'b1 || pc_o[i] !== 64'h5000 || ins_o[i] !== 32'h77 || get_cnt(i) != 1) begin
                errors++;
                $display("FAIL rmid_push[%0d] got v=%b pc=%h ins=%h cnt=%0d exp 1 5000 77 1",
                         i, pv[i], pc_o[i], ins_o[i], get_cnt(i));
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill();
        test_nop();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_buf.md
PIPE_BUF -- requirements
Module: pipe_buf

Interface
REQ-001 Parameter INS_W, default 32, instruction width in bits.
REQ-002 Parameter PC_W, default 64, PC width in bits.
REQ-003 Parameter DEPTH, default 2, entry count; legal range 1..16, power of two.
REQ-004 Parameter NOP_INS, default INS_W'h13 (ADDI x0,x0,0), instruction stored when i_pre_nop=1.
REQ-005 i_clk  in  1  single clock; all state on rising edge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_flush  in  1  discard all stored entries.
REQ-008 i_pre_nop  in  1  incoming entry is a bubble.
REQ-009 i_pre_stall  in  1  forces o_pre_ready low.
REQ-010 i_pre_valid  in  1  upstream entry valid.
REQ-011 o_pre_ready  out  1  buffer accepts an entry this cycle.
REQ-012 i_ifu_ins  in  INS_W  upstream instruction.
REQ-013 i_ifu_pc  in  PC_W  upstream PC.
REQ-014 o_post_valid  out  1  head entry valid.
REQ-015 i_post_ready  in  1  downstream accepts head.
REQ-016 o_ins  out  INS_W  head instruction.
REQ-017 o_pc  out  PC_W  head PC.
REQ-018 o_nop  out  1  head entry is a bubble.
REQ-019 o_count  out  clog2(DEPTH+1)  occupied entries.
REQ-020 o_full  out  1  o_count==DEPTH.

Function
REQ-021 Storage: DEPTH-entry circular FIFO of {ins, pc, nop}; write pointer, read pointer, occupancy counter.
REQ-022 push = i_pre_valid & o_pre_ready; pop = o_post_valid & i_post_ready.
REQ-023 o_pre_ready = !i_pre_stall & (!o_full | pop), combinational; i_flush does not affect o_pre_ready.
REQ-024 Full-and-popping: push accepted same cycle as pop, giving 1 entry/cycle sustained throughput for every DEPTH including 1.
REQ-025 On push, stored ins = NOP_INS when i_pre_nop=1, else i_ifu_ins; stored pc = i_ifu_pc; stored nop = i_pre_nop.
REQ-026 o_post_valid = (o_count != 0); o_ins/o_pc/o_nop driven from read-pointer entry, no combinational path from i_ifu_* to outputs.
REQ-027 Latency: entry pushed at edge N is visible on outputs after edge N, i.e. one cycle; no bypass when empty.
REQ-028 Counter: push&!pop +1; pop&!push -1; both or neither unchanged; never exceeds DEPTH nor underflows.
REQ-029 Pointers increment modulo DEPTH on push/pop respectively; wrap from DEPTH-1 to 0.
REQ-030 Empty: pop impossible (o_post_valid=0); simultaneous i_pre_valid pushes only.
REQ-031 i_flush=1: next edge sets count 0, both pointers 0; a concurrent push and pop are both discarded; flush dominates.
REQ-032 When o_post_valid=0, o_ins/o_pc/o_nop hold last read-entry contents; consumers ignore them.
REQ-033 Head outputs stay stable while o_post_valid=1 and i_post_ready=0 (no flush).
REQ-034 i_pre_stall with o_full=0 still blocks push; pop proceeds unaffected.

Reset
REQ-035 i_rst=1 at edge: count 0, pointers 0, all entry storage zero; outputs o_post_valid=0, o_ins=0, o_pc=0, o_nop=0, o_count=0, o_full=0.
REQ-036 Reset dominates flush and handshakes; reset mid-stream discards all entries, no pop registered.
REQ-037 o_pre_ready during reset follows REQ-023 with count 0 (=!i_pre_stall); pushes that cycle are discarded.

Verification
REQ-038 DEPTH=2: push pc 0x80000000,0x80000004 with i_post_ready=0 -> o_count=2, o_full=1, o_pre_ready=0, o_pc=0x80000000 held.
REQ-039 DEPTH=1, i_pre_valid=i_post_ready=1 for 8 cycles, pcs +4 -> o_post_valid=1 every cycle after first, pcs in order, no loss/duplication.
REQ-040 i_pre_nop=1 with i_ifu_ins=0x00A00093 -> o_ins=0x00000013, o_nop=1 one cycle later.
REQ-041 Full DEPTH=4 plus push, pop and i_flush same cycle -> next cycle o_count=0, o_post_valid=0, pushed entry absent.
REQ-042 DEPTH=4, 10 pushes / pops interleaved randomly with i_pre_stall pulses -> output order equals accepted order across pointer wrap; no push while stall=1.
REQ-043 i_rst asserted with o_count=3 -> next cycle all outputs zero, subsequent push appears after one cycle.
